// File: rtl/gray_bin_pkg.sv
// Shared constants and helpers for the pipelined Gray/binary converter.
package gray_bin_pkg;

  localparam logic MODE_G2B = 1'b0;
  localparam logic MODE_B2G = 1'b1;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/gray_bin_conv_pipe_if.sv
// Valid/ready word stream carrying a conversion mode and a sideband tag.
interface gray_bin_conv_pipe_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);
  import gray_bin_pkg::*;

  logic             valid;
  logic             ready;
  logic             mode;
  logic [WIDTH-1:0] data;
  logic [TAG_W-1:0] tag;

  modport master (output valid, output mode, output data, output tag, input  ready);
  modport slave  (input  valid, input  mode, input  data, input  tag, output ready);

endinterface

// File: rtl/gray_bin_stage.sv
// One pipeline stage: resolves its Gray->binary chunk [HI:LO] MSB-first from the
// carried prefix bit; the first stage also performs the whole binary->Gray step.
module gray_bin_stage
  import gray_bin_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int HI    = 7,
  parameter int LO    = 0,
  parameter bit EMPTY = 1'b0,
  parameter bit FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             valid_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             prefix_i,
  output logic             valid_o,
  output logic             mode_o,
  output logic [WIDTH-1:0] data_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             valid_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [TAG_W-1:0] tag_q;
  logic             run;

  always_comb begin
    data_d = data_i;
    run    = prefix_i;
    if (mode_i == MODE_G2B) begin
      // Bits outside this chunk stay raw Gray (below) or already resolved (above).
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!EMPTY && (i <= HI) && (i >= LO)) begin
          run       = run ^ data_i[i];
          data_d[i] = run;
        end
      end
    end else if (FIRST) begin
      data_d = data_i ^ (data_i >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_G2B;
      data_q  <= '0;
      tag_q   <= '0;
    end else if (en_i) begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      data_q  <= data_d;
      tag_q   <= tag_i;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign data_o  = data_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray/binary converter: fixed STAGES-cycle latency,
// one global advance enable, bubbles travel with the words.
module gray_bin_conv_pipe
  import gray_bin_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gray_bin_conv_pipe_if.slave  in_if,
  gray_bin_conv_pipe_if.master out_if
);

  localparam int C = ceil_div(WIDTH, STAGES);

  // Index 0 is the input word; index k is the output of stage k.
  logic             valid_s [0:STAGES];
  logic             mode_s  [0:STAGES];
  logic [WIDTH-1:0] data_s  [0:STAGES];
  logic [TAG_W-1:0] tag_s   [0:STAGES];
  logic             adv;

  assign valid_s[0] = in_if.valid;
  assign mode_s[0]  = in_if.mode;
  assign data_s[0]  = in_if.data;
  assign tag_s[0]   = in_if.tag;

  assign adv         = out_if.ready | ~valid_s[STAGES];
  assign in_if.ready = adv;

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    localparam int HI     = WIDTH - 1 - (k - 1) * C;
    localparam int LO_RAW = WIDTH - k * C;
    localparam int LO     = (LO_RAW < 0) ? 0 : LO_RAW;
    localparam bit EMPTY  = (HI < 0);

    logic prefix;

    // The bit just above this chunk is the last one the previous stage resolved.
    if ((k == 1) || EMPTY) begin : g_pfx_none
      assign prefix = 1'b0;
    end else begin : g_pfx_carry
      assign prefix = data_s[k-1][HI+1];
    end

    gray_bin_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .HI    (HI),
      .LO    (LO),
      .EMPTY (EMPTY),
      .FIRST (k == 1)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_i     (adv),
      .valid_i  (valid_s[k-1]),
      .mode_i   (mode_s[k-1]),
      .data_i   (data_s[k-1]),
      .tag_i    (tag_s[k-1]),
      .prefix_i (prefix),
      .valid_o  (valid_s[k]),
      .mode_o   (mode_s[k]),
      .data_o   (data_s[k]),
      .tag_o    (tag_s[k])
    );
  end

  assign out_if.valid = valid_s[STAGES];
  assign out_if.mode  = mode_s[STAGES];
  assign out_if.data  = data_s[STAGES];
  assign out_if.tag   = tag_s[STAGES];

endmodule

// File: tb/tb_gray_bin_conv_pipe.sv
// Directed bench for the Gray/binary converter: a 4-bit/2-stage instance for the
// hand-computed vectors and an 8-bit/3-stage instance for a randomized stream.
module tb_gray_bin_conv_pipe;
  import gray_bin_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gray_bin_conv_pipe_if #(.WIDTH(4), .TAG_W(4)) a_in  ();
  gray_bin_conv_pipe_if #(.WIDTH(4), .TAG_W(4)) a_out ();
  gray_bin_conv_pipe_if #(.WIDTH(8), .TAG_W(4)) b_in  ();
  gray_bin_conv_pipe_if #(.WIDTH(8), .TAG_W(4)) b_out ();

  gray_bin_conv_pipe #(.WIDTH(4), .STAGES(2), .TAG_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_if(a_in), .out_if(a_out));

  gray_bin_conv_pipe #(.WIDTH(8), .STAGES(3), .TAG_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_if(b_in), .out_if(b_out));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_g2b8(input logic [7:0] g);
    logic [7:0] b;
    b = '0;
    for (int s = 0; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [7:0] ref_b2g8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [3:0]  gq     [16];
  logic [3:0]  bp_in  [4];
  logic [3:0]  bp_exp [4];
  logic [3:0]  v;
  logic [3:0]  held_d, held_t;
  logic        stalled, held8;
  int          sent, rcvd, sent8, rcvd8, stalls;
  logic [12:0] exp_q [$];
  int          cyc_q [$];
  int          stall_q [$];
  logic [12:0] e;
  logic [7:0]  bd;
  int          lat;

  initial begin
    rst_n = 1'b0;
    a_in.valid = 1'b1; a_in.mode = MODE_G2B; a_in.data = 4'b1010; a_in.tag = 4'h5;
    a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.mode = MODE_G2B; b_in.data = 8'h00; b_in.tag = 4'h0;
    b_out.ready = 1'b1;
    #1;

    // Reset held with a word offered.
    for (int c = 0; c < 3; c++) begin
      chk("rst_hold", 64'({a_out.valid, a_out.data}), 64'(0));
      step();
    end
    chk("rst_side", 64'({a_out.mode, a_out.tag}), 64'(0));
    a_in.valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rdy_after_rst", 64'(a_in.ready), 64'(1));

    // Gray->binary stream, 2-cycle latency, consecutive outputs.
    a_in.valid = 1'b1; a_in.mode = MODE_G2B; a_in.data = 4'b1010; a_in.tag = 4'h1;
    step();
    chk("g2b_lat", 64'(a_out.valid), 64'(0));
    a_in.data = 4'b0111; a_in.tag = 4'h2;
    step();
    chk("g2b_w0", 64'({a_out.valid, a_out.data}), 64'({1'b1, 4'b1100}));
    a_in.data = 4'b1111; a_in.tag = 4'h3;
    step();
    chk("g2b_w1", 64'({a_out.valid, a_out.data}), 64'({1'b1, 4'b0101}));
    a_in.valid = 1'b0;
    step();
    chk("g2b_w2", 64'({a_out.valid, a_out.data}), 64'({1'b1, 4'b1010}));
    step();
    chk("g2b_drain", 64'(a_out.valid), 64'(0));

    // Binary->Gray with tag.
    a_in.valid = 1'b1; a_in.mode = MODE_B2G; a_in.data = 4'b1100; a_in.tag = 4'hA;
    step();
    a_in.valid = 1'b0;
    chk("b2g_lat", 64'(a_out.valid), 64'(0));
    step();
    chk("b2g_word", 64'({a_out.valid, a_out.mode, a_out.tag, a_out.data}),
        64'({1'b1, 1'b1, 4'hA, 4'b1010}));

    // All 16 values to Gray, then the DUT's Gray words back to binary.
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        v = 4'(c - 2);
        chk("b2g_sweep", 64'({a_out.valid, a_out.mode, a_out.data}),
            64'({1'b1, 1'b1, v ^ (v >> 1)}));
        gq[c-2] = a_out.data;
      end
      a_in.valid = (c < 16); a_in.mode = MODE_B2G;
      a_in.data = 4'(c); a_in.tag = 4'(c);
      step();
    end
    for (int c = 0; c < 18; c++) begin
      if (c >= 2) begin
        chk("roundtrip", 64'({a_out.valid, a_out.mode, a_out.tag, a_out.data}),
            64'({1'b1, 1'b0, 4'(c - 2), 4'(c - 2)}));
      end
      a_in.valid = (c < 16); a_in.mode = MODE_G2B;
      a_in.data = gq[(c < 16) ? c : 15]; a_in.tag = 4'(c);
      step();
    end

    // Backpressure: out_ready low in cycles 3..6 of a 4-word burst.
    bp_in  = '{4'b0001, 4'b0011, 4'b0110, 4'b1000};
    bp_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1111};
    sent = 0; rcvd = 0; stalled = 1'b0; held_d = '0; held_t = '0;
    for (int c = 0; (c < 20) && (rcvd < 4); c++) begin
      a_out.ready = !((c >= 3) && (c <= 6));
      a_in.valid  = (sent < 4);
      a_in.mode   = MODE_G2B;
      a_in.data   = bp_in[(sent < 4) ? sent : 3];
      a_in.tag    = 4'(sent);
      #1;
      if (stalled)
        chk("bp_stable", 64'({a_out.valid, a_out.tag, a_out.data}), 64'({1'b1, held_t, held_d}));
      if (a_out.valid && !a_out.ready) begin
        chk("bp_inready", 64'(a_in.ready), 64'(0));
        stalled = 1'b1; held_d = a_out.data; held_t = a_out.tag;
      end else begin
        stalled = 1'b0;
      end
      if (a_out.valid && a_out.ready) begin
        chk("bp_order", 64'({a_out.tag, a_out.data}), 64'({4'(rcvd), bp_exp[rcvd]}));
        rcvd++;
      end
      if (a_in.valid && a_in.ready) sent++;
      step();
    end
    chk("bp_count", 64'({32'(sent), 32'(rcvd)}), 64'({32'd4, 32'd4}));
    a_in.valid = 1'b0; a_out.ready = 1'b1;

    // Reset with two words in flight.
    a_in.valid = 1'b1; a_in.mode = MODE_G2B; a_in.data = 4'b0101;
    step();
    a_in.data = 4'b0110;
    step();
    a_in.valid = 1'b0;
    chk("mid_inflight", 64'(a_out.valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_async", 64'({a_out.valid, a_out.data}), 64'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mid_no_stale", 64'(a_out.valid), 64'(0));
    end

    // 8-bit, 3-stage: directed latency in both modes.
    b_in.valid = 1'b1; b_in.mode = MODE_G2B; b_in.data = 8'hB4; b_in.tag = 4'h3;
    step();
    chk("w8_lat1", 64'(b_out.valid), 64'(0));
    b_in.mode = MODE_B2G; b_in.data = 8'hD8; b_in.tag = 4'h4;
    step();
    b_in.valid = 1'b0;
    chk("w8_lat2", 64'(b_out.valid), 64'(0));
    step();
    chk("w8_g2b", 64'({b_out.valid, b_out.mode, b_out.tag, b_out.data}),
        64'({1'b1, 1'b0, 4'h3, 8'hD8}));
    step();
    chk("w8_b2g", 64'({b_out.valid, b_out.mode, b_out.tag, b_out.data}),
        64'({1'b1, 1'b1, 4'h4, 8'hB4}));
    step();

    // 8-bit, 3-stage: 1000 random words with random backpressure.
    sent8 = 0; rcvd8 = 0; stalls = 0; held8 = 1'b0;
    for (int cyc = 0; (cyc < 6000) && (rcvd8 < 1000); cyc++) begin
      b_out.ready = ($urandom_range(0, 9) < 7);
      if (!held8) begin
        b_in.valid = (sent8 < 1000) && ($urandom_range(0, 9) < 8);
        b_in.mode  = 1'($urandom_range(0, 1));
        b_in.data  = 8'($urandom_range(0, 255));
        b_in.tag   = 4'($urandom_range(0, 15));
      end
      #1;
      if (b_out.valid && b_out.ready) begin
        if (exp_q.size() == 0) begin
          chk("rand_extra", 64'(exp_q.size()), 64'(1));
        end else begin
          e = exp_q.pop_front();
          lat = cyc - cyc_q.pop_front();
          chk("rand_word", 64'({8'(lat), b_out.mode, b_out.tag, b_out.data}),
              64'({8'(3 + stalls - stall_q.pop_front()), e}));
        end
        rcvd8++;
      end
      if (b_out.valid && !b_out.ready) stalls++;
      if (b_in.valid && b_in.ready) begin
        bd = (b_in.mode == MODE_G2B) ? ref_g2b8(b_in.data) : ref_b2g8(b_in.data);
        exp_q.push_back({b_in.mode, b_in.tag, bd});
        cyc_q.push_back(cyc);
        stall_q.push_back(stalls);
        sent8++;
        held8 = 1'b0;
      end else begin
        held8 = b_in.valid;
      end
      step();
    end
    chk("rand_done", 64'({32'(sent8), 32'(rcvd8)}), 64'({32'd1000, 32'd1000}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gray_bin_conv_pipe.md
Name: gray_bin_conv_pipe

Overview:
- Parametrised, pipelined, bidirectional Gray/binary code converter with valid/ready handshake on input and output.
- Per-transaction mode select: Gray→binary (MSB-first prefix XOR) or binary→Gray (adjacent XOR).
- The Gray→binary prefix-XOR chain is split across STAGES register stages, so wide words close timing.
- Sits between counter/encoder sources (e.g. async-FIFO pointers, rotary encoders) and binary-domain consumers; an optional tag travels alongside each word.

Parameters:
- WIDTH, 8, data word width in bits (≥2).
- STAGES, 2, pipeline register stages = fixed latency (1..WIDTH).
- TAG_W, 4, width of sideband tag carried unchanged with each word (≥1).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  converter accepts the input word this cycle.
- in_mode  input  1  0 = Gray→binary, 1 = binary→Gray; sampled with the word.
- in_data  input  WIDTH  word to convert.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  converted word present.
- out_ready  input  1  downstream accepts the output.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode the word was converted with.
- out_tag  output  TAG_W  tag accepted with the word.

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0; out_valid = 0, out_data = 0, out_mode = 0, out_tag = 0. in_ready = 1 once released. Any in-flight words are discarded on reset mid-operation.
- Global advance enable: adv = out_ready | ~out_valid. in_ready = adv (combinational from out_ready and the last-stage valid bit).
- Transfer rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
- Pipeline movement:
  - When adv = 1, every stage loads from the previous stage; stage 1 loads the input word, and its valid bit = in_valid.
  - When adv = 0, all stages hold their contents.
  - Bubbles are not collapsed.
- Latency: exactly STAGES cycles from acceptance to out_valid with no backpressure. Throughput: 1 word/cycle.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Chunk size C = ceil(WIDTH/STAGES).
  - Stage k (1-based) resolves bits [WIDTH-1-(k-1)C : max(0, WIDTH-kC)], MSB-first, from the running b bit of stage k-1.
  - Unresolved bits ride along as raw g bits.
  - Stages with empty chunks (when STAGES·C > WIDTH) pass data through.
- Binary→Gray: g = b ^ (b >> 1), computed fully in stage 1; later stages pass it through.
- Mode and tag are pipelined alongside the data; no data-dependent behaviour.
- Simultaneous input and output transfers in the same cycle are legal and sustain full rate.
- in_valid while in_ready = 0: the input side holds in_data, in_mode and in_tag stable (source obligation). The converter neither samples nor drops the word.
- out_valid, once asserted, remains asserted with stable out_data, out_mode and out_tag until out_ready.

Decomposition:
- Package gray_bin_pkg holds:
  - mode constants MODE_G2B = 1'b0 and MODE_B2G = 1'b1;
  - a chunk-size function ceil_div(WIDTH, STAGES).
- One natural sub-module, gray_bin_stage: a single pipeline register stage with parameters LO/HI bit bounds and an enable. Inputs are running data, valid, mode and tag, plus the carried prefix bit. It is instantiated STAGES times via generate.

Test Plan (WIDTH=4, STAGES=2, TAG_W=4 unless noted):
- Reset with in_valid high → out_valid = 0 and out_data = 0 throughout reset. in_ready = 1 in the first cycle after rst_n rises.
- Mode 0, in_data = 1010, 0111 and 1111 on consecutive cycles, out_ready = 1 → out_data = 1100, 0101 and 1010, each 2 cycles after its input, on consecutive cycles.
- Mode 1, in_data = 1100, tag = 4'hA → out_data = 1010, out_mode = 1, out_tag = A, 2 cycles later. Then round-trip all 16 values through mode 0 → identity.
- Backpressure: stream 4 words with out_ready = 0 from cycle 3 to cycle 6 → in_ready = 0 while out_valid = 1. out_data stays stable, and all 4 words arrive in order with no loss or duplication.
- Reset mid-stream: assert rst_n = 0 with 2 words in flight → out_valid drops asynchronously. After release, no stale words appear.
- WIDTH=8, STAGES=3, random 1000 words with random out_ready → every output matches the reference XOR model, in order, with latency 3 when unstalled.
